read_page_seq_ctrl: RTL and testbench
=====================================

Name: read_page_seq_ctrl

Overview:
Parametrised page-read sequencer for the NAND flash controller. It walks one page read through the same phases as the existing read controller: block check, data transfer, per-chunk ECC evaluation, correction, useless-data marking and last-page fill. It adds bounded re-read retries on uncorrectable ECC, a watchdog timeout, configurable settle delays and a per-read result summary. It sits between the command front-end (en_read) and the low-level flash timing sequencer (low_state).

Parameters:
PAGE_W, 2, width of page_idx
FILL_PAGE, 2, page index that triggers the 0x55 fill instead of flag clear
ROWCHK_DLY, 1, cycles waited in ROWCHK before sampling row_status (minimum 1)
SETTLE_CYC, 2, cycles waited in ECC_WAIT before sampling low_state (minimum 1)
MAX_RETRY, 2, re-reads allowed per read after uncorrectable ECC (0 = none)
TMO_CYC, 4096, watchdog limit in cycles per state; width is $clog2(TMO_CYC+1)
LS_CHUNK_DONE, 18, low_state code for chunk data transferred
LS_PAGE_IDLE, 12, low_state code for page finished

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en_read  in  1  read request, sampled in IDLE
row_status  in  2  0 = pending, 1 = block good, 2 = block bad, 3 = treated as pending
ecc_status  in  2  0 = pending, 1 = clean, 2 = correctable, 3 = uncorrectable
page_idx  in  PAGE_W  page index within block of the current read
fix_done  in  1  correction engine finished
low_state  in  5  low-level sequencer state
read_state  out  4  current FSM state (encoding below)
busy  out  1  high in every state except INIT and IDLE
reread_req  out  1  1-cycle pulse: restart page read at low level
fill55_req  out  1  1-cycle pulse in FILL55
clr_flag_req  out  1  1-cycle pulse in CLR_FLAG
done  out  1  1-cycle pulse in FINISH
result  out  2  valid from done until next START: 0 = clean, 1 = corrected, 2 = useless, 3 = bad block
timeout_err  out  1  sticky; cleared in START
retry_cnt  out  $clog2(MAX_RETRY+1)  retries used this read; cleared in START

Behaviour:
- Reset: read_state = 0. All outputs, counters, the internal useless flag and the internal corrected flag are 0.
- State encoding: 0 INIT, 1 IDLE, 2 START, 3 ROWCHK, 4 READ, 5 ECC_WAIT, 6 ECC_EVAL, 7 CORRECT, 8 MARK_BAD, 9 CHK_USELESS, 10 CHK_PAGE, 11 FILL55, 12 CLR_FLAG, 13 FINISH, 14 RETRY, 15 TIMEOUT.
- INIT goes to IDLE unconditionally.
- IDLE goes to START when en_read = 1; otherwise stays in IDLE.
- START clears retry_cnt, timeout_err, the useless flag and the corrected flag, then goes to ROWCHK.
- ROWCHK waits ROWCHK_DLY cycles, then samples row_status:
  - 1: go to READ.
  - 2: result = 3, go to FINISH.
  - 0 or 3: stay in ROWCHK.
- READ goes to ECC_WAIT when low_state = LS_CHUNK_DONE.
- ECC_WAIT waits SETTLE_CYC cycles (counter cleared on every entry), then:
  - low_state = LS_PAGE_IDLE: go to CHK_USELESS. PAGE_IDLE has priority if both codes could match.
  - low_state = LS_CHUNK_DONE: go to ECC_EVAL.
  - otherwise stay.
- ECC_EVAL on ecc_status:
  - 0: stay.
  - 1: go to ECC_WAIT.
  - 2: set the corrected flag, go to CORRECT.
  - 3: go to MARK_BAD.
- CORRECT goes to ECC_WAIT on fix_done.
- MARK_BAD:
  - retry_cnt < MAX_RETRY: go to RETRY.
  - otherwise: set the useless flag, go to ECC_WAIT.
- RETRY pulses reread_req, increments retry_cnt, clears the corrected flag, then goes to READ.
- CHK_USELESS: useless flag set goes to CHK_PAGE; clear goes to FINISH.
- CHK_PAGE: page_idx == FILL_PAGE goes to FILL55; otherwise goes to CLR_FLAG.
- FILL55 and CLR_FLAG each pulse their request for one cycle, then go to FINISH.
- FINISH pulses done and goes to IDLE. result is latched on entry to FINISH:
  - 3 if the read was aborted by a bad block,
  - 2 if the useless flag is set,
  - 1 if the corrected flag is set,
  - 0 otherwise.
- Watchdog: one counter, active in states 3–7. It resets on every state change. On reaching TMO_CYC it forces TIMEOUT. TIMEOUT sets timeout_err, sets result = 2 and goes to FINISH. Watchdog transitions have priority over normal transitions.
- en_read is ignored while busy. No queuing.
- Reset asserted mid-read returns to INIT immediately. No pulse completes.
- Undefined encodings cannot occur with 4 bits. The default branch still goes to INIT.

Decomposition:
- Shared package (flash_rd_pkg): state encoding constants, row_status/ecc_status/result code constants, LS_* defaults.
- Sub-module: rd_watchdog. Holds the timeout counter with inputs clear, enable, limit and output expired. Also reused by the write controller.

Test Plan:
- Clean page: en_read, row_status = 1 after 1 cycle, 2 chunks with ecc = 1, then low_state = 12 -> states 1,2,3,4,5,6,5,6,5,9,13,1; done with result = 0; no fill55_req or clr_flag_req.
- Bad block: row_status = 2 -> FINISH reached 2 cycles after ROWCHK entry; result = 3; READ never entered.
- Correctable: ecc = 2, fix_done after 5 cycles -> CORRECT held 5 cycles; result = 1.
- Uncorrectable, MAX_RETRY = 2, ecc = 3 on every attempt, page_idx = 2 -> exactly 2 reread_req pulses, retry_cnt = 2, then fill55_req once, result = 2. Repeat with page_idx = 1 -> clr_flag_req instead of fill55_req.
- Uncorrectable then clean on retry -> 1 reread_req; result = 0; no fill or clear pulse.
- Timeout with TMO_CYC = 16: low_state stuck in READ -> TIMEOUT after 16 cycles, timeout_err = 1, done pulse, result = 2. Separately, assert rst mid-ECC_WAIT -> read_state = 0 and all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/flash_rd_pkg.sv
// Shared encodings for the NAND flash read path: FSM states, status and
// result codes, and default low-level sequencer state codes.
package flash_rd_pkg;

  typedef enum logic [3:0] {
    ST_INIT        = 4'd0,
    ST_IDLE        = 4'd1,
    ST_START       = 4'd2,
    ST_ROWCHK      = 4'd3,
    ST_READ        = 4'd4,
    ST_ECC_WAIT    = 4'd5,
    ST_ECC_EVAL    = 4'd6,
    ST_CORRECT     = 4'd7,
    ST_MARK_BAD    = 4'd8,
    ST_CHK_USELESS = 4'd9,
    ST_CHK_PAGE    = 4'd10,
    ST_FILL55      = 4'd11,
    ST_CLR_FLAG    = 4'd12,
    ST_FINISH      = 4'd13,
    ST_RETRY       = 4'd14,
    ST_TIMEOUT     = 4'd15
  } rd_state_e;

  localparam logic [1:0] ROW_PENDING = 2'd0;
  localparam logic [1:0] ROW_GOOD    = 2'd1;
  localparam logic [1:0] ROW_BAD     = 2'd2;

  localparam logic [1:0] ECC_PENDING = 2'd0;
  localparam logic [1:0] ECC_CLEAN   = 2'd1;
  localparam logic [1:0] ECC_CORR    = 2'd2;
  localparam logic [1:0] ECC_UNCORR  = 2'd3;

  localparam logic [1:0] RES_CLEAN     = 2'd0;
  localparam logic [1:0] RES_CORRECTED = 2'd1;
  localparam logic [1:0] RES_USELESS   = 2'd2;
  localparam logic [1:0] RES_BAD_BLOCK = 2'd3;

  localparam logic [4:0] LS_CHUNK_DONE_DEF = 5'd18;
  localparam logic [4:0] LS_PAGE_IDLE_DEF  = 5'd12;

endpackage

// File: rtl/rd_watchdog.sv
// Per-state watchdog: counts enabled cycles and flags the cycle on which the
// count reaches the limit. Shared with the write controller.
module rd_watchdog #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);
  assign expired = enable && (cnt_inc == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/read_page_seq_ctrl.sv
// Page-read sequencer: row check, chunk transfer, ECC evaluation/correction,
// bounded re-read retries, useless-page fill/clear and a per-state watchdog.
module read_page_seq_ctrl
  import flash_rd_pkg::*;
#(
  parameter int         PAGE_W        = 2,
  parameter int         FILL_PAGE     = 2,
  parameter int         ROWCHK_DLY    = 1,
  parameter int         SETTLE_CYC    = 2,
  parameter int         MAX_RETRY     = 2,
  parameter int         TMO_CYC       = 4096,
  parameter logic [4:0] LS_CHUNK_DONE = LS_CHUNK_DONE_DEF,
  parameter logic [4:0] LS_PAGE_IDLE  = LS_PAGE_IDLE_DEF,
  localparam int        RC_W          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_read,
  input  logic [1:0]        row_status,
  input  logic [1:0]        ecc_status,
  input  logic [PAGE_W-1:0] page_idx,
  input  logic              fix_done,
  input  logic [4:0]        low_state,
  output logic [3:0]        read_state,
  output logic              busy,
  output logic              reread_req,
  output logic              fill55_req,
  output logic              clr_flag_req,
  output logic              done,
  output logic [1:0]        result,
  output logic              timeout_err,
  output logic [RC_W-1:0]   retry_cnt
);

  localparam int TW      = $clog2(TMO_CYC + 1);
  localparam int DLY_MAX = (ROWCHK_DLY > SETTLE_CYC) ? ROWCHK_DLY : SETTLE_CYC;
  localparam int DW      = $clog2(DLY_MAX + 1);

  rd_state_e state;
  rd_state_e next_state;

  logic [DW-1:0] dly_cnt;
  logic          dly_done;
  logic          state_chg;
  logic          useless_flag;
  logic          corrected_flag;
  logic          wd_en;
  logic          wd_expired;

  // One delay counter serves both ROWCHK and ECC_WAIT; it restarts on every state change.
  assign dly_done  = (state == ST_ROWCHK) ? (dly_cnt >= DW'(ROWCHK_DLY))
                                          : (dly_cnt >= DW'(SETTLE_CYC));
  assign state_chg = (next_state != state);
  assign wd_en     = (state >= ST_ROWCHK) && (state <= ST_CORRECT);

  rd_watchdog #(
    .CNT_W (TW)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (wd_en),
    .limit   (TW'(TMO_CYC)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (wd_expired) begin
      next_state = ST_TIMEOUT;
    end else begin
      case (state)
        ST_INIT:     next_state = ST_IDLE;
        ST_IDLE:     if (en_read) next_state = ST_START;
        ST_START:    next_state = ST_ROWCHK;
        ST_ROWCHK: begin
          if (dly_done) begin
            if (row_status == ROW_GOOD)     next_state = ST_READ;
            else if (row_status == ROW_BAD) next_state = ST_FINISH;
          end
        end
        ST_READ:     if (low_state == LS_CHUNK_DONE) next_state = ST_ECC_WAIT;
        ST_ECC_WAIT: begin
          if (dly_done) begin
            if (low_state == LS_PAGE_IDLE)       next_state = ST_CHK_USELESS;
            else if (low_state == LS_CHUNK_DONE) next_state = ST_ECC_EVAL;
          end
        end
        ST_ECC_EVAL: begin
          case (ecc_status)
            ECC_CLEAN:  next_state = ST_ECC_WAIT;
            ECC_CORR:   next_state = ST_CORRECT;
            ECC_UNCORR: next_state = ST_MARK_BAD;
            default:    next_state = ST_ECC_EVAL;
          endcase
        end
        ST_CORRECT:  if (fix_done) next_state = ST_ECC_WAIT;
        ST_MARK_BAD: next_state = (retry_cnt < RC_W'(MAX_RETRY)) ? ST_RETRY : ST_ECC_WAIT;
        ST_RETRY:    next_state = ST_READ;
        ST_CHK_USELESS: next_state = useless_flag ? ST_CHK_PAGE : ST_FINISH;
        ST_CHK_PAGE: next_state = (page_idx == PAGE_W'(FILL_PAGE)) ? ST_FILL55 : ST_CLR_FLAG;
        ST_FILL55:   next_state = ST_FINISH;
        ST_CLR_FLAG: next_state = ST_FINISH;
        ST_TIMEOUT:  next_state = ST_FINISH;
        ST_FINISH:   next_state = ST_IDLE;
        default:     next_state = ST_INIT;
      endcase
    end
  end

  // Flags and summary bookkeeping follow the transition actually taken, so a
  // watchdog override never leaves a half-applied flag behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_cnt        <= '0;
      useless_flag   <= 1'b0;
      corrected_flag <= 1'b0;
      retry_cnt      <= '0;
      timeout_err    <= 1'b0;
      result         <= RES_CLEAN;
    end else begin
      if (state_chg) begin
        dly_cnt <= '0;
      end else if (!dly_done) begin
        dly_cnt <= dly_cnt + DW'(1);
      end

      case (state)
        ST_START: begin
          retry_cnt      <= '0;
          timeout_err    <= 1'b0;
          useless_flag   <= 1'b0;
          corrected_flag <= 1'b0;
        end
        ST_ECC_EVAL: if (next_state == ST_CORRECT)  corrected_flag <= 1'b1;
        ST_MARK_BAD: if (next_state == ST_ECC_WAIT) useless_flag   <= 1'b1;
        ST_RETRY: begin
          retry_cnt      <= retry_cnt + RC_W'(1);
          corrected_flag <= 1'b0;
        end
        ST_TIMEOUT: begin
          timeout_err <= 1'b1;
          result      <= RES_USELESS;
        end
        default: ;
      endcase

      if ((next_state == ST_FINISH) && (state != ST_FINISH)) begin
        if (state == ST_ROWCHK)                            result <= RES_BAD_BLOCK;
        else if ((state == ST_TIMEOUT) || useless_flag)    result <= RES_USELESS;
        else if (corrected_flag)                           result <= RES_CORRECTED;
        else                                               result <= RES_CLEAN;
      end
    end
  end

  assign read_state   = state;
  assign busy         = (state != ST_INIT) && (state != ST_IDLE);
  assign reread_req   = (state == ST_RETRY);
  assign fill55_req   = (state == ST_FILL55);
  assign clr_flag_req = (state == ST_CLR_FLAG);
  assign done         = (state == ST_FINISH);

endmodule

// File: tb/tb_read_page_seq_ctrl.sv
// Directed bench for read_page_seq_ctrl: drives page-read scenarios reactively
// and compares state traces, pulse counts and results against hand-derived values.
module tb_read_page_seq_ctrl;
  import flash_rd_pkg::*;

  logic       clk;
  logic       rst;
  logic       en_read;
  logic [1:0] row_status;
  logic [1:0] ecc_status;
  logic [1:0] page_idx;
  logic       fix_done;
  logic [4:0] low_state;
  logic [3:0] read_state;
  logic       busy;
  logic       reread_req;
  logic       fill55_req;
  logic       clr_flag_req;
  logic       done;
  logic [1:0] result;
  logic       timeout_err;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  read_page_seq_ctrl #(
    .PAGE_W     (2),
    .FILL_PAGE  (2),
    .ROWCHK_DLY (1),
    .SETTLE_CYC (2),
    .MAX_RETRY  (2),
    .TMO_CYC    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_read      (en_read),
    .row_status   (row_status),
    .ecc_status   (ecc_status),
    .page_idx     (page_idx),
    .fix_done     (fix_done),
    .low_state    (low_state),
    .read_state   (read_state),
    .busy         (busy),
    .reread_req   (reread_req),
    .fill55_req   (fill55_req),
    .clr_flag_req (clr_flag_req),
    .done         (done),
    .result       (result),
    .timeout_err  (timeout_err),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples 1 time unit after each rising edge.
  int          ent [16];
  int          n_reread, n_fill, n_clr, n_done, corr_cyc, read_cyc;
  int          cyc = 0;
  int          t_rowchk, t_finish;
  logic [63:0] sig;
  logic [3:0]  prev;
  logic [1:0]  res_at_done;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (read_state != prev) begin
      sig = {sig[59:0], read_state};
      ent[read_state]++;
      if (read_state == ST_ROWCHK) t_rowchk = cyc;
      if (read_state == ST_FINISH) t_finish = cyc;
      prev = read_state;
    end
    if (reread_req)   n_reread++;
    if (fill55_req)   n_fill++;
    if (clr_flag_req) n_clr++;
    if (done) begin
      n_done++;
      res_at_done = result;
    end
    if (read_state == ST_CORRECT) corr_cyc++;
    if (read_state == ST_READ)    read_cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearMon();
    foreach (ent[i]) ent[i] = 0;
    n_reread    = 0;
    n_fill      = 0;
    n_clr       = 0;
    n_done      = 0;
    corr_cyc    = 0;
    read_cyc    = 0;
    t_rowchk    = 0;
    t_finish    = 0;
    res_at_done = 2'b00;
    sig         = 64'(read_state);
    prev        = read_state;
  endtask

  task automatic applyStimulus(input logic [1:0] row, input logic [1:0] ecc,
                               input logic [1:0] page, input logic [4:0] low);
    @(negedge clk);
    row_status = row;
    ecc_status = ecc;
    page_idx   = page;
    low_state  = low;
    fix_done   = 1'b0;
    clearMon();
    en_read    = 1'b1;
    @(negedge clk);
    en_read    = 1'b0;
  endtask

  task automatic waitState(input logic [3:0] target, input string tag);
    int k = 0;
    while (read_state !== target && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (read_state !== target) checkOutput(tag, 64'(read_state), 64'(target));
  endtask

  task automatic waitEntries(input int st, input int n, input string tag);
    int k = 0;
    while (ent[st] < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (ent[st] < n) checkOutput(tag, 64'(ent[st]), 64'(n));
  endtask

  task automatic finishRead(input string tag);
    waitEntries(ST_FINISH, 1, tag);
    waitState(ST_IDLE, tag);
  endtask

  initial begin
    rst        = 1'b1;
    en_read    = 1'b0;
    row_status = 2'd0;
    ecc_status = 2'd0;
    page_idx   = 2'd0;
    fix_done   = 1'b0;
    low_state  = 5'd0;
    prev       = 4'd0;
    sig        = 64'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_state", 64'(read_state), 64'(0));
    checkOutput("rst_outputs", 64'({busy, reread_req, fill55_req, clr_flag_req, done,
                                    result, timeout_err, retry_cnt}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("init_to_idle", 64'(read_state), 64'(ST_IDLE));

    // Clean page, two chunks
    applyStimulus(2'd1, 2'd1, 2'd0, LS_CHUNK_DONE_DEF);
    waitEntries(ST_ECC_EVAL, 2, "clean_eval2");
    low_state = LS_PAGE_IDLE_DEF;
    finishRead("clean_done");
    checkOutput("clean_trace", sig, 64'h1234_5656_59D1);
    checkOutput("clean_result", 64'(res_at_done), 64'(0));
    checkOutput("clean_done_cnt", 64'(n_done), 64'(1));
    checkOutput("clean_fill_clr", 64'(n_fill + n_clr), 64'(0));

    // Bad block
    applyStimulus(2'd2, 2'd1, 2'd0, LS_CHUNK_DONE_DEF);
    finishRead("bad_done");
    checkOutput("bad_latency", 64'(t_finish - t_rowchk), 64'(2));
    checkOutput("bad_result", 64'(res_at_done), 64'(3));
    checkOutput("bad_trace", sig, 64'h123D1);
    checkOutput("bad_no_read", 64'(ent[ST_READ]), 64'(0));

    // Correctable chunk, fix_done on the fifth CORRECT cycle
    applyStimulus(2'd1, 2'd2, 2'd0, LS_CHUNK_DONE_DEF);
    waitState(ST_CORRECT, "corr_enter");
    ecc_status = 2'd1;
    low_state  = LS_PAGE_IDLE_DEF;
    repeat (4) @(negedge clk);
    fix_done = 1'b1;
    @(negedge clk);
    fix_done = 1'b0;
    finishRead("corr_done");
    checkOutput("corr_cycles", 64'(corr_cyc), 64'(5));
    checkOutput("corr_result", 64'(res_at_done), 64'(1));
    checkOutput("corr_trace", sig, 64'h1234_5675_9D1);

    // Uncorrectable on every attempt, fill page
    applyStimulus(2'd1, 2'd3, 2'd2, LS_CHUNK_DONE_DEF);
    waitEntries(ST_MARK_BAD, 3, "unc2_markbad");
    low_state = LS_PAGE_IDLE_DEF;
    finishRead("unc2_done");
    checkOutput("unc2_reread", 64'(n_reread), 64'(2));
    checkOutput("unc2_retry_cnt", 64'(retry_cnt), 64'(2));
    checkOutput("unc2_fill", 64'(n_fill), 64'(1));
    checkOutput("unc2_clr", 64'(n_clr), 64'(0));
    checkOutput("unc2_result", 64'(res_at_done), 64'(2));

    // Uncorrectable on every attempt, non-fill page
    applyStimulus(2'd1, 2'd3, 2'd1, LS_CHUNK_DONE_DEF);
    waitEntries(ST_MARK_BAD, 3, "unc1_markbad");
    low_state = LS_PAGE_IDLE_DEF;
    finishRead("unc1_done");
    checkOutput("unc1_reread", 64'(n_reread), 64'(2));
    checkOutput("unc1_clr", 64'(n_clr), 64'(1));
    checkOutput("unc1_fill", 64'(n_fill), 64'(0));
    checkOutput("unc1_result", 64'(res_at_done), 64'(2));

    // Uncorrectable, then clean after one re-read
    applyStimulus(2'd1, 2'd3, 2'd2, LS_CHUNK_DONE_DEF);
    waitEntries(ST_MARK_BAD, 1, "rc_markbad");
    ecc_status = 2'd1;
    waitEntries(ST_ECC_EVAL, 2, "rc_eval2");
    low_state = LS_PAGE_IDLE_DEF;
    finishRead("rc_done");
    checkOutput("rc_reread", 64'(n_reread), 64'(1));
    checkOutput("rc_retry_cnt", 64'(retry_cnt), 64'(1));
    checkOutput("rc_result", 64'(res_at_done), 64'(0));
    checkOutput("rc_fill_clr", 64'(n_fill + n_clr), 64'(0));

    // Watchdog: stuck in READ
    applyStimulus(2'd1, 2'd1, 2'd0, 5'd0);
    finishRead("tmo_done");
    checkOutput("tmo_read_cycles", 64'(read_cyc), 64'(16));
    checkOutput("tmo_err", 64'(timeout_err), 64'(1));
    checkOutput("tmo_result", 64'(res_at_done), 64'(2));
    checkOutput("tmo_done_cnt", 64'(n_done), 64'(1));
    checkOutput("tmo_trace", sig, 64'h1234FD1);

    // Asynchronous reset in the middle of ECC_WAIT
    applyStimulus(2'd1, 2'd0, 2'd0, LS_CHUNK_DONE_DEF);
    waitState(ST_ECC_WAIT, "arst_ecc_wait");
    checkOutput("start_clears_tmo", 64'(timeout_err), 64'(0));
    checkOutput("busy_in_read", 64'(busy), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_state", 64'(read_state), 64'(0));
    checkOutput("arst_outputs", 64'({busy, reread_req, fill55_req, clr_flag_req, done,
                                     result, timeout_err, retry_cnt}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("arst_recover_idle", 64'(read_state), 64'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "[TB] time limit");
  end

endmodule
